// File: rtl/spi_wrapper_shared_pkg.sv
// Shared types and command encodings for the SPI-RAM wrapper.
package spi_wrapper_shared_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        CHK_CMD    = 3'd1,
        WRITE      = 3'd2,
        READ_ADD   = 3'd3,
        READ_DATA  = 3'd4,
        READ_WAIT  = 3'd5,
        READ_SHIFT = 3'd6,
        HOLD       = 3'd7
    } spi_slv_state_e;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

endpackage

// File: rtl/spi_tx_serializer.sv
// MSB-first parallel-to-serial shifter driving MISO for one RAM read word.
module spi_tx_serializer #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  shift_en,
    output logic                  miso,
    output logic                  done_c
);

    localparam int unsigned CW = $clog2(DATA_WIDTH + 1);

    logic [DATA_WIDTH-1:0] sh_q, sh_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  busy_q, busy_d;
    logic                  miso_q, miso_d;

    // Load puts the MSB on the line right away; each enabled cycle advances one bit.
    always_comb begin
        sh_d   = sh_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        miso_d = 1'b0;
        if (load) begin
            miso_d = tx_data[DATA_WIDTH-1];
            sh_d   = tx_data << 1;
            cnt_d  = CW'(DATA_WIDTH - 1);
            busy_d = 1'b1;
        end else if (shift_en && busy_q && (cnt_q != '0)) begin
            miso_d = sh_q[DATA_WIDTH-1];
            sh_d   = sh_q << 1;
            cnt_d  = cnt_q - CW'(1);
        end else begin
            busy_d = 1'b0;
        end
    end

    // Serializer state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            sh_q   <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            miso_q <= 1'b0;
        end else begin
            sh_q   <= sh_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            miso_q <= miso_d;
        end
    end

    assign miso   = miso_q;
    assign done_c = busy_q && (cnt_q == '0);

endmodule

// File: rtl/spi_slave_burst.sv
// SPI slave front-end: command frame deserialiser, read-word serialiser, burst and timeout control.
module spi_slave_burst
    import spi_wrapper_shared_pkg::*;
#(
    parameter int unsigned ADDR_SIZE  = 8,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned BURST_EN   = 1,
    parameter int unsigned TX_TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  SS_n,
    input  logic                  MOSI,
    output logic                  MISO,
    output logic [ADDR_SIZE+1:0]  rx_data,
    output logic                  rx_valid,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  err
);

    localparam int unsigned FRAME_W = ADDR_SIZE + 2;
    localparam int unsigned BCW     = $clog2(FRAME_W);
    localparam int unsigned TCW     = $clog2(TX_TIMEOUT + 1);

    spi_slv_state_e       state_q, state_d;
    logic [FRAME_W-1:0]   shift_q, shift_d;
    logic [BCW-1:0]       bit_cnt_q, bit_cnt_d;
    logic [TCW-1:0]       tcnt_q, tcnt_d;
    logic                 rd_addr_done_q, rd_addr_done_d;
    logic [FRAME_W-1:0]   rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 err_q, err_d;
    logic                 ser_load_c, ser_shift_c, ser_done_c;

    // Next-state, frame capture, timeout and burst control.
    always_comb begin
        state_d        = state_q;
        shift_d        = shift_q;
        bit_cnt_d      = bit_cnt_q;
        tcnt_d         = tcnt_q;
        rd_addr_done_d = rd_addr_done_q;
        rx_data_d      = rx_data_q;
        rx_valid_d     = 1'b0;
        err_d          = 1'b0;
        ser_load_c     = 1'b0;
        ser_shift_c    = 1'b0;

        if (SS_n) begin
            state_d   = IDLE;
            bit_cnt_d = '0;
            tcnt_d    = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d   = CHK_CMD;
                    bit_cnt_d = '0;
                    tcnt_d    = '0;
                end
                CHK_CMD: begin
                    bit_cnt_d = '0;
                    if (!MOSI)              state_d = WRITE;
                    else if (rd_addr_done_q) state_d = READ_DATA;
                    else                     state_d = READ_ADD;
                end
                WRITE, READ_ADD, READ_DATA: begin
                    shift_d = {shift_q[FRAME_W-2:0], MOSI};
                    if (bit_cnt_q == BCW'(FRAME_W - 1)) begin
                        rx_data_d  = shift_d;
                        rx_valid_d = 1'b1;
                        bit_cnt_d  = '0;
                        if (state_q == READ_DATA) begin
                            rd_addr_done_d = 1'b0;
                            tcnt_d         = '0;
                            state_d        = READ_WAIT;
                        end else begin
                            if (state_q == READ_ADD) rd_addr_done_d = 1'b1;
                            state_d = HOLD;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + BCW'(1);
                    end
                end
                READ_WAIT: begin
                    if (tx_valid) begin
                        ser_load_c = 1'b1;
                        tcnt_d     = '0;
                        state_d    = READ_SHIFT;
                    end else if (tcnt_q == TCW'(TX_TIMEOUT - 1)) begin
                        err_d   = 1'b1;
                        tcnt_d  = '0;
                        state_d = HOLD;
                    end else begin
                        tcnt_d = tcnt_q + TCW'(1);
                    end
                end
                READ_SHIFT: begin
                    ser_shift_c = 1'b1;
                    if (ser_done_c) begin
                        if (BURST_EN != 0) begin
                            rx_valid_d = 1'b1;
                            rx_data_d  = {CMD_RD_DATA, {ADDR_SIZE{1'b0}}};
                            state_d    = READ_WAIT;
                        end else begin
                            state_d = HOLD;
                        end
                    end
                end
                HOLD: state_d = HOLD;
                default: state_d = IDLE;
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            shift_q        <= '0;
            bit_cnt_q      <= '0;
            tcnt_q         <= '0;
            rd_addr_done_q <= 1'b0;
            rx_data_q      <= '0;
            rx_valid_q     <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            shift_q        <= shift_d;
            bit_cnt_q      <= bit_cnt_d;
            tcnt_q         <= tcnt_d;
            rd_addr_done_q <= rd_addr_done_d;
            rx_data_q      <= rx_data_d;
            rx_valid_q     <= rx_valid_d;
            err_q          <= err_d;
        end
    end

    spi_tx_serializer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ser (
        .clk      (clk),
        .rst      (rst),
        .load     (ser_load_c),
        .tx_data  (tx_data),
        .shift_en (ser_shift_c),
        .miso     (MISO),
        .done_c   (ser_done_c)
    );

    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign err      = err_q;

endmodule

// File: tb/tb_spi_slave_burst.sv
// Directed bench for spi_slave_burst (ADDR_SIZE=8, DATA_WIDTH=8, TX_TIMEOUT=16).
module tb_spi_slave_burst;
    import spi_wrapper_shared_pkg::*;

    logic       clk;
    logic       rst;
    logic       SS_n;
    logic       MOSI;
    logic       MISO;
    logic [9:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       err;

    int n_vec = 0;
    int n_err = 0;

    spi_slave_burst #(
        .ADDR_SIZE  (8),
        .DATA_WIDTH (8),
        .BURST_EN   (1),
        .TX_TIMEOUT (16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .SS_n     (SS_n),
        .MOSI     (MOSI),
        .MISO     (MISO),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // From IDLE: select, routing bit, then 10 frame bits; returns with the strobe cycle visible.
    task automatic send_frame(input logic route, input logic [9:0] pat);
        SS_n = 1'b0;
        MOSI = 1'b0;
        tick();
        MOSI = route;
        tick();
        for (int k = 9; k >= 0; k--) begin
            MOSI = pat[k];
            tick();
        end
        MOSI = 1'b0;
    endtask

    // Supply a read word after 'dly' idle cycles and check the 8 MISO bits; SS_n = rel on the last bit.
    task automatic read_word(input logic [7:0] d, input int dly, input logic rel);
        repeat (dly) tick();
        tx_valid = 1'b1;
        tx_data  = d;
        tick();
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        for (int b = 7; b >= 0; b--) begin
            check($sformatf("miso_bit%0d", b), 32'(MISO), 32'(d[b]));
            if (b == 0) SS_n = rel;
            tick();
        end
        check("miso_after_word", 32'(MISO), 32'd0);
    endtask

    int seen;
    int at;
    logic [9:0] pat;

    initial begin
        rst = 1'b1; SS_n = 1'b1; MOSI = 1'b0; tx_data = 8'h00; tx_valid = 1'b0;
        tick(); tick();
        rst = 1'b0;
        check("rst_miso", 32'(MISO), 32'd0);
        check("rst_rx_valid", 32'(rx_valid), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_rx_data", 32'(rx_data), 32'd0);
        check("rst_state", 32'(dut.state_q), 32'(IDLE));

        // 1: write-address frame, strobe 12 cycles after select
        pat = {CMD_WR_ADDR, 8'hA5};
        SS_n = 1'b0;
        seen = 0; at = 0;
        for (int i = 0; i < 14; i++) begin
            MOSI = (i >= 2 && i < 12) ? pat[11 - i] : 1'b0;
            tick();
            if (rx_valid) begin seen++; at = i + 1; end
        end
        check("t1_strobe_count", 32'(seen), 32'd1);
        check("t1_strobe_cycle", 32'(at), 32'd12);
        check("t1_rx_data", 32'(rx_data), 32'h0A5);
        check("t1_state_hold", 32'(dut.state_q), 32'(HOLD));
        SS_n = 1'b1; tick();
        check("t1_idle", 32'(dut.state_q), 32'(IDLE));

        // 2: read address, read data, single word then release
        send_frame(1'b1, {CMD_RD_ADDR, 8'h30});
        check("t2_addr_strobe", 32'(rx_valid), 32'd1);
        check("t2_addr_data", 32'(rx_data), 32'h230);
        check("t2_addr_flag", 32'(dut.rd_addr_done_q), 32'd1);
        SS_n = 1'b1; tick();
        send_frame(1'b1, {CMD_RD_DATA, 8'h00});
        check("t2_data_strobe", 32'(rx_valid), 32'd1);
        check("t2_data_rx", 32'(rx_data), 32'h300);
        check("t2_state_wait", 32'(dut.state_q), 32'(READ_WAIT));
        read_word(8'hC3, 2, 1'b1);
        check("t2_no_burst", 32'(rx_valid), 32'd0);
        check("t2_idle", 32'(dut.state_q), 32'(IDLE));

        // 3: burst continuation while select stays low
        send_frame(1'b1, {CMD_RD_ADDR, 8'h30});
        SS_n = 1'b1; tick();
        send_frame(1'b1, {CMD_RD_DATA, 8'h00});
        read_word(8'hC3, 2, 1'b0);
        check("t3_burst_strobe", 32'(rx_valid), 32'd1);
        check("t3_burst_rx", 32'(rx_data), 32'h300);
        check("t3_burst_wait", 32'(dut.state_q), 32'(READ_WAIT));
        read_word(8'h5A, 0, 1'b1);
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            if (rx_valid) seen++;
            tick();
        end
        check("t3_no_more_strobes", 32'(seen), 32'd0);

        // 4: read-data command with no address yet, aborted mid-payload
        SS_n = 1'b0; MOSI = 1'b0; tick();
        MOSI = 1'b1; tick();
        check("t4_routed_read_add", 32'(dut.state_q), 32'(READ_ADD));
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            MOSI = 1'b1;
            tick();
            if (rx_valid) seen++;
        end
        SS_n = 1'b1; tick();
        if (rx_valid) seen++;
        check("t4_no_strobe", 32'(seen), 32'd0);
        check("t4_idle", 32'(dut.state_q), 32'(IDLE));
        check("t4_flag_kept", 32'(dut.rd_addr_done_q), 32'd0);
        check("t4_rx_data_held", 32'(rx_data), 32'h300);
        send_frame(1'b0, {CMD_WR_DATA, 8'hFF});
        check("t4_clean_frame", 32'(rx_data), 32'h1FF);
        check("t4_clean_strobe", 32'(rx_valid), 32'd1);
        SS_n = 1'b1; tick();

        // 5: tx_valid timeout
        send_frame(1'b1, {CMD_RD_ADDR, 8'h12});
        SS_n = 1'b1; tick();
        send_frame(1'b1, {CMD_RD_DATA, 8'h00});
        at = 0;
        for (int n = 1; n <= 40; n++) begin
            tick();
            if (err) begin at = n; break; end
        end
        check("t5_err_cycle", 32'(at), 32'd16);
        check("t5_miso", 32'(MISO), 32'd0);
        check("t5_state_hold", 32'(dut.state_q), 32'(HOLD));
        tx_valid = 1'b1; tx_data = 8'hFF; tick();
        tx_valid = 1'b0; tick();
        check("t5_err_one_cycle", 32'(err), 32'd0);
        check("t5_ignore_tx_valid", 32'(dut.state_q), 32'(HOLD));
        check("t5_miso_hold", 32'(MISO), 32'd0);
        SS_n = 1'b1; tick();
        check("t5_idle", 32'(dut.state_q), 32'(IDLE));

        // 6: reset in the middle of shifting out a word
        send_frame(1'b1, {CMD_RD_ADDR, 8'h44});
        SS_n = 1'b1; tick();
        send_frame(1'b1, {CMD_RD_DATA, 8'h00});
        tx_valid = 1'b1; tx_data = 8'hFF; tick();
        tx_valid = 1'b0; tx_data = 8'h00;
        tick(); tick();
        check("t6_shifting", 32'(MISO), 32'd1);
        rst = 1'b1; tick();
        check("t6_miso", 32'(MISO), 32'd0);
        check("t6_rx_valid", 32'(rx_valid), 32'd0);
        check("t6_err", 32'(err), 32'd0);
        check("t6_state", 32'(dut.state_q), 32'(IDLE));
        check("t6_flag", 32'(dut.rd_addr_done_q), 32'd0);
        check("t6_rx_data", 32'(rx_data), 32'd0);
        SS_n = 1'b1; tick();
        rst = 1'b0; tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
